// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full adder/subtractor cell walks the operands
// LSB first, one bit per clock, behind valid/ready handshakes on both sides.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_brw,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid may not depend on ready, and ready is registered on both ports.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic a_bit, b_bit, r_bit, c_next;

  always_comb begin
    a_bit  = a_q[cnt_q];
    b_bit  = b_q[cnt_q];
    r_bit  = a_bit ^ b_bit ^ c_q;
    c_next = mode_q ? ((~a_bit & b_bit) | (c_q & ~(a_bit ^ b_bit)))
                    : ((a_bit & b_bit)  | (c_q & (a_bit ^ b_bit)));

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          a_d        = a;
          b_d        = b;
          mode_d     = mode;
          c_d        = cin;
          cnt_d      = '0;
          res_d      = '0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          // Ready comes up one cycle after re-entering IDLE, forcing an idle gap.
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        res_d = {r_bit, res_q[WIDTH-1:1]};
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          ovf_d       = mode_q ? ((a_bit != b_bit) && (r_bit != a_bit))
                               : ((a_bit == b_bit) && (r_bit != a_bit));
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      c_q         <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Result-side outputs are masked so they read zero whenever out_valid is low.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = out_valid_q ? res_q : '0;
  assign cout_brw  = out_valid_q & c_q;
  assign ovf       = out_valid_q & ovf_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub (WIDTH=8): directed corner jobs, reset abort and
// randomized add/sub jobs scored against an integer-arithmetic model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout_brw;
  logic         ovf;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W+1:0] exp_q[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout_brw  (cout_brw),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout_brw, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic mm);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    logic [W-1:0] r;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (!mm) begin
      ur = ua + ub + int'(mc);
      sr = sa + sb + int'(mc);
      co = (ur > 255);
    end else begin
      ur = ua - ub - int'(mc);
      sr = sa - sb - int'(mc);
      co = (ur < 0);
    end
    r  = W'(ur & 255);
    ov = (sr > 127) || (sr < -128);
    return {ov, co, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    a    = W'($urandom);
    b    = W'($urandom);
    cin  = 1'($urandom);
    mode = 1'($urandom);
  endtask

  // Driver: one full job, from handshake-in to handshake-out, with checks.
  task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tmode,
                         input int hold, input logic early);
    logic [W+1:0] exp;
    int k;
    int lat;
    exp_q.push_back(model(ta, tb_v, tcin, tmode));
    k = 0;
    while (!in_ready && k < 10) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    a = ta; b = tb_v; cin = tcin; mode = tmode; in_valid = 1'b1;
    tick();
    scramble_inputs();
    in_valid  = 1'($urandom);
    out_ready = early;
    check("busy_run", 32'({busy, in_ready, out_valid}), 32'b100);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
      check("zero_while_invalid", 32'({result, cout_brw, ovf}), 32'd0);
      scramble_inputs();
    end
    exp = exp_q.pop_front();
    if (lat == 0) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b0;
      return;
    end
    out_ready = 1'b0;
    check("latency", 32'(lat), 32'd8);
    check("result", 32'({ovf, cout_brw, result}), 32'(exp));
    check("done_flags", 32'({busy, in_ready}), 32'b10);
    for (int h = 0; h < hold; h++) begin
      scramble_inputs();
      in_valid = 1'($urandom);
      tick();
      check("hold_stable", 32'({out_valid, in_ready, ovf, cout_brw, result}),
            32'({1'b1, 1'b0, exp}));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    check("exit_idle", 32'({out_valid, busy, in_ready, ovf, cout_brw, result}), 32'd0);
    tick();
    check("in_ready_after_gap", 32'({in_ready, busy}), 32'b10);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    tick();
    tick();
    check("reset_state", 32'({in_ready, out_valid, busy, ovf, cout_brw, result}),
          32'({1'b1, 12'd0}));
    rst = 1'b0;
    tick();

    // Directed corners
    run_job(8'h5A, 8'h3C, 1'b0, 1'b0, 5, 1'b0);
    run_job(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b1);
    run_job(8'h00, 8'h00, 1'b1, 1'b0, 1, 1'b0);
    run_job(8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0);
    run_job(8'h00, 8'h01, 1'b0, 1'b1, 2, 1'b1);
    run_job(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b0);
    run_job(8'h7F, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_job(8'h80, 8'h00, 1'b1, 1'b1, 0, 1'b0);

    // Reset aborts a job while bit 4 would be processed
    a = 8'h12; b = 8'h34; cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    check("abort_state", 32'({in_ready, out_valid, busy, ovf, cout_brw, result}),
          32'({1'b1, 12'd0}));
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_output_after_abort", 32'({out_valid, busy}), 32'd0);
    end
    run_job(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0);

    // Reset wins over an input handshake on the same edge
    a = 8'h33; b = 8'h44; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_priority", 32'({busy, in_ready}), 32'b01);
    tick();
    check("rst_priority_idle", 32'(busy), 32'd0);

    // Randomized jobs
    for (int j = 0; j < 200; j++) begin
      run_job(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
